// File: rtl/reg_write_bank.sv
// Write side and storage of the integer register file: one writeback port,
// a hardwired zero register at the top index, and an optional write-through.
module reg_write_bank_slice #(
  parameter int WIDTH  = 64,
  parameter int BYPASS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset)     r_q <= '0;
    else if (i_we) r_q <= i_d;
  end

  // i_we already excludes reset, so the bypass is suppressed while reset is high
  if (BYPASS != 0) begin : g_byp
    assign o_q = i_we ? i_d : r_q;
  end else begin : g_nobyp
    assign o_q = r_q;
  end
endmodule

module reg_write_bank #(
  parameter int WIDTH  = 64,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1,
  parameter int CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   RegWrite,
  input  logic [4:0]             WriteRegister,
  input  logic [WIDTH-1:0]       WriteData,
  output logic [NREGS*WIDTH-1:0] RegDatabus,
  output logic [CNT_W-1:0]       WriteCount,
  output logic [4:0]             LastWritten
);
  localparam logic [4:0] XZR = 5'(NREGS - 1);

  logic             w_we;
  logic [NREGS-1:0] w_sel;

  assign w_we = RegWrite && (WriteRegister != XZR) && !reset;

  for (genvar j = 0; j < NREGS; j++) begin : g_reg
    if (j == NREGS - 1) begin : g_zero
      assign w_sel[j] = 1'b0;
      assign RegDatabus[j*WIDTH +: WIDTH] = '0;
    end else begin : g_store
      assign w_sel[j] = w_we && (WriteRegister == 5'(j));
      reg_write_bank_slice #(.WIDTH(WIDTH), .BYPASS(BYPASS)) u_slice (
        .clk   (clk),
        .reset (reset),
        .i_we  (w_sel[j]),
        .i_d   (WriteData),
        .o_q   (RegDatabus[j*WIDTH +: WIDTH])
      );
    end
  end

  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_last <= '0;
    end else if (w_we) begin
      r_cnt  <= r_cnt + 1'b1;
      r_last <= WriteRegister;
    end
  end

  assign WriteCount  = r_cnt;
  assign LastWritten = r_last;
endmodule

// File: tb/tb_reg_write_bank.sv
// Self-checking bench: array-based register file model compared every cycle,
// plus literal checks for layout, zero register, bypass and counter wrap.
module tb_reg_write_bank;
  logic          clk = 1'b0;
  logic          reset;
  logic          RegWrite;
  logic [4:0]    WriteRegister;
  logic [63:0]   WriteData;
  logic [2047:0] bus_b, bus_n, bus_4;
  logic [31:0]   cnt_b, cnt_n;
  logic [3:0]    cnt_4;
  logic [4:0]    last_b, last_n, last_4;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  reg_write_bank #(.BYPASS(1)) u_b (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .RegDatabus(bus_b), .WriteCount(cnt_b), .LastWritten(last_b));
  reg_write_bank #(.BYPASS(0)) u_n (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .RegDatabus(bus_n), .WriteCount(cnt_n), .LastWritten(last_n));
  reg_write_bank #(.BYPASS(1), .CNT_W(4)) u_4 (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .RegDatabus(bus_4), .WriteCount(cnt_4), .LastWritten(last_4));

  // model: committed contents, count of committed writes, last index
  logic [63:0] m_reg [32];
  int unsigned m_cnt;
  int          m_last;

  always @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < 32; j++) m_reg[j] = '0;
      m_cnt  = 0;
      m_last = 0;
    end else if (RegWrite === 1'b1 && WriteRegister != 5'd31) begin
      m_reg[WriteRegister] = WriteData;
      m_cnt  = m_cnt + 1;
      m_last = int'(WriteRegister);
    end
  end

  function automatic logic [63:0] exp_slice(input int j, input bit byp);
    if (j == 31) return '0;
    if (byp && !reset && RegWrite === 1'b1 && int'(WriteRegister) == j) return WriteData;
    return m_reg[j];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int j = 0; j < 32; j++) begin
        check($sformatf("byp_x%0d", j), bus_b[j*64 +: 64], exp_slice(j, 1'b1));
        check($sformatf("nob_x%0d", j), bus_n[j*64 +: 64], exp_slice(j, 1'b0));
        check($sformatf("c4_x%0d", j),  bus_4[j*64 +: 64], exp_slice(j, 1'b1));
      end
      check("cnt_b",  64'(cnt_b),  64'(m_cnt));
      check("cnt_n",  64'(cnt_n),  64'(m_cnt));
      check("cnt_4",  64'(cnt_4),  64'(m_cnt % 16));
      check("last_b", 64'(last_b), 64'(m_last));
      check("last_n", 64'(last_n), 64'(m_last));
      check("last_4", 64'(last_4), 64'(m_last));
    end
  end

  task automatic wr(input logic [4:0] a, input logic [63:0] d);
    @(posedge clk); #1;
    reset = 1'b0; RegWrite = 1'b1; WriteRegister = a; WriteData = d;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    reset = 1'b0; RegWrite = 1'b0; WriteRegister = 'x; WriteData = 64'($urandom);
  endtask

  task automatic rst1();
    @(posedge clk); #1;
    reset = 1'b1; RegWrite = 1'b0;
  endtask

  initial begin
    reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0; chk_en = 1'b1;
    @(negedge clk);
    check("reset_cnt", 64'(cnt_b), 64'd0);
    check("reset_bus_x0", bus_b[63:0], 64'd0);

    // 1: random writes, then 2-cycle reset carrying a write to X5
    for (int i = 0; i < 6; i++) wr(5'($urandom_range(0, 30)), {$urandom, $urandom});
    @(posedge clk); #1;
    reset = 1'b1; RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 64'hDEADBEEF;
    @(posedge clk);
    idle();
    @(negedge clk);
    check("t1_x5", bus_b[383:320], 64'd0);
    check("t1_bus_zero", 64'(bus_b != '0), 64'd0);
    check("t1_cnt", 64'(cnt_b), 64'd0);
    check("t1_last", 64'(last_b), 64'd0);

    // 2: layout
    wr(5'd3, 64'h0123456789ABCDEF);
    wr(5'd30, 64'hFFFFFFFFFFFFFFFF);
    idle();
    @(negedge clk);
    check("t2_x3", bus_n[255:192], 64'h0123456789ABCDEF);
    check("t2_x30", bus_n[1983:1920], 64'hFFFFFFFFFFFFFFFF);
    check("t2_x4", bus_n[319:256], 64'd0);
    check("t2_cnt", 64'(cnt_n), 64'd2);
    check("t2_last", 64'(last_n), 64'd30);

    // 3: zero register
    wr(5'd31, 64'hAAAAAAAAAAAAAAAA);
    @(negedge clk);
    check("t3_x31_during", bus_b[2047:1984], 64'd0);
    idle();
    @(negedge clk);
    check("t3_x31_after", bus_b[2047:1984], 64'd0);
    check("t3_cnt", 64'(cnt_b), 64'd2);
    check("t3_last", 64'(last_b), 64'd30);

    // 4: write-through vs committed-only
    wr(5'd7, 64'h11);
    wr(5'd7, 64'h22);
    @(negedge clk);
    check("t4_byp_before", bus_b[511:448], 64'h22);
    check("t4_nob_before", bus_n[511:448], 64'h11);
    idle();
    @(negedge clk);
    check("t4_byp_after", bus_b[511:448], 64'h22);
    check("t4_nob_after", bus_n[511:448], 64'h22);

    // 5: every register back-to-back, then X0 overwritten twice
    rst1();
    for (int j = 0; j < 31; j++) wr(5'(j), 64'((j << 8) | 8'h5A));
    wr(5'd0, 64'h1);
    wr(5'd0, 64'h2);
    idle();
    @(negedge clk);
    check("t5_x0", bus_n[63:0], 64'h2);
    check("t5_x1", bus_n[127:64], 64'h15A);
    check("t5_x30", bus_n[1983:1920], 64'h1E5A);
    check("t5_cnt", 64'(cnt_n), 64'd33);
    check("t5_last", 64'(last_n), 64'd0);
    check("t5_cnt4", 64'(cnt_4), 64'd1);

    // 6: 4-bit counter wrap, then reset mid-stream
    rst1();
    for (int i = 0; i < 17; i++) wr(5'(i % 31), 64'(i + 100));
    idle();
    @(negedge clk);
    check("t6_cnt4_wrap", 64'(cnt_4), 64'd1);
    check("t6_cnt32", 64'(cnt_b), 64'd17);
    wr(5'd9, 64'h99);
    wr(5'd10, 64'hA0);
    @(posedge clk); #1;
    reset = 1'b1; RegWrite = 1'b1; WriteRegister = 5'd11; WriteData = 64'hBB;
    idle();
    @(negedge clk);
    check("t6_cnt4_rst", 64'(cnt_4), 64'd0);
    check("t6_x11_rst", bus_4[767:704], 64'd0);
    check("t6_x9_rst", bus_4[639:576], 64'd0);
    idle();
    idle();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
